// File: rtl/ps2_command_sender.sv
`timescale 1ns/1ps
// ps2_command_sender
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// using the PS/2 host request-to-send sequence: hold the clock low, place the
// start bit, release the clock, then let the device clock out 8 data bits
// (LSB first), odd parity and the stop bit, and finally read the device ACK.
// Both PS/2 lines are open-drain: they are either pulled to 0 or released.
// They are shared with the keyboard receive path.
//
// Ports
//   CLOCK_50                       in    system clock (50 MHz)
//   reset                          in    asynchronous, active-high reset
//   the_command[7:0]               in    command byte, captured when a send is accepted
//   send_command                   in    single-cycle send request (ignored while busy)
//   PS2_CLK                        inout PS/2 clock, drive 0 or release
//   PS2_DAT                        inout PS/2 data, drive 0 or release
//   busy                           out   high from acceptance until the DONE/ERROR cycle
//   command_was_sent               out   one-cycle pulse on successful completion
//   error_communication_timed_out  out   one-cycle pulse on timeout (or NACK, see below)
//
// Parameters
//   INHIBIT_CYCLES        cycles PS2_CLK is held low before the start bit
//   START_TIMEOUT_CYCLES  max wait for the first device falling edge after release
//   XFER_TIMEOUT_CYCLES   max time from the first device falling edge to bus idle
//
// Build option
//   PS2_TX_ACK_CHECK_EN   when defined, a NACK (data high on the 11th falling
//                         edge) ends the transfer in ERROR. When undefined the
//                         ACK value is ignored.
//
// States
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | lines released, waiting for send_command
//   S_INHIBIT   | PS2_CLK held low; start bit placed in the final cycle
//   S_RTS       | PS2_CLK released, start bit held, waiting for device clock
//   S_XFER      | data/parity/stop shifted out on device falling edges
//   S_ACK       | lines released, ACK sampled on the 11th falling edge
//   S_WAIT_IDLE | waiting for the device to release both lines
//   S_DONE      | one-cycle success pulse
//   S_ERROR     | one-cycle error pulse

module ps2_command_sender #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam int MAX_AB   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                              INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CYC  = (MAX_AB > XFER_TIMEOUT_CYCLES) ? MAX_AB : XFER_TIMEOUT_CYCLES;
    localparam int TW       = $clog2(MAX_CYC + 1);

    // Timer is a down-counter: loaded with N-1 on entry, terminal count is zero,
    // so the state occupies exactly N cycles.
    localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LOAD   = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] XFER_LOAD    = TW'(XFER_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_XFER      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [9:0]      shift_q, shift_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic            clk_low_q, clk_low_d;
    logic            dat_low_q, dat_low_d;
    logic            busy_q, busy_d;
    logic            sent_q, sent_d;
    logic            err_q, err_d;

    logic            clk_meta_q, clk_sync_q, clk_prev_q;
    logic            dat_meta_q, dat_sync_q;
    logic            falling;
    logic            tx_low;

    // ------------------------------------------------------------------
    // Open-drain line drivers
    // ------------------------------------------------------------------
    assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

    assign busy                          = busy_q;
    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;

    // ------------------------------------------------------------------
    // Two-flop synchronizers. They reset to 1 (idle bus level) so no
    // falling edge is seen right after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign falling = clk_prev_q & ~clk_sync_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            clk_low_q <= clk_low_d;
            dat_low_q <= dat_low_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        tx_low    = dat_low_q;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        busy_d    = 1'b0;
        sent_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (send_command) begin
                    // {stop, odd parity, data}; bit 0 goes out first
                    shift_d  = {1'b1, ~^the_command, the_command};
                    bitcnt_d = 4'd0;
                    timer_d  = INHIBIT_LOAD;
                    state_d  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (timer_q == '0) begin
                    timer_d = START_LOAD;
                    state_d = S_RTS;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            S_RTS: begin
                if (timer_q == '0) begin
                    state_d = S_ERROR;
                end else if (falling) begin
                    // The first device edge already carries data bit 0.
                    tx_low   = ~shift_q[0];
                    bitcnt_d = 4'd1;
                    timer_d  = XFER_LOAD;
                    state_d  = S_XFER;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            S_XFER: begin
                if (timer_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (falling) begin
                        tx_low   = ~shift_q[bitcnt_q];
                        bitcnt_d = bitcnt_q + 4'd1;
                        // Edge 10 places the stop bit, which is a release,
                        // so ACK (lines released) starts right away.
                        if (bitcnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end

            S_ACK: begin
                if (timer_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (falling) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        if (dat_sync_q) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
`else
                        state_d = S_WAIT_IDLE;
`endif
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (timer_q == '0) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (clk_sync_q && dat_sync_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE, S_ERROR: begin
                timer_d  = '0;
                bitcnt_d = '0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the open-drain
        // enables and pulses change cleanly on the clock edge.
        clk_low_d = (state_d == S_INHIBIT);

        unique case (state_d)
            S_INHIBIT: dat_low_d = (timer_d == '0);
            S_RTS:     dat_low_d = 1'b1;
            S_XFER:    dat_low_d = tx_low;
            default:   dat_low_d = 1'b0;
        endcase

        busy_d = (state_d == S_INHIBIT) || (state_d == S_RTS) || (state_d == S_XFER) ||
                 (state_d == S_ACK) || (state_d == S_WAIT_IDLE);
        sent_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

endmodule

// File: tb/tb_ps2_command_sender.sv
`timescale 1ns/1ps
// Bench for ps2_command_sender with shortened timing parameters. A behavioural
// PS/2 device generates the clock, samples the host data on each low phase
// and optionally ACKs; expected frame contents come from arithmetic on the
// command byte.

module tb_ps2_command_sender;

    localparam int INH      = 40;
    localparam int START_TO = 300;
    localparam int XFER_TO  = 1200;
    // Pin edge to XFER entry: two synchronizer flops plus the edge-detect flop.
    localparam int SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd = 8'h00;
    logic       send = 1'b0;
    logic       busy, sent, err;
    wire        ps2_clk, ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sent_cnt = 0;
    int err_cnt = 0;
    int fall1_cyc = 0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_command_sender #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO)
    ) dut (
        .CLOCK_50                     (clk),
        .reset                        (reset),
        .the_command                  (cmd),
        .send_command                 (send),
        .PS2_CLK                      (ps2_clk),
        .PS2_DAT                      (ps2_dat),
        .busy                         (busy),
        .command_was_sent             (sent),
        .error_communication_timed_out(err)
    );

    always #10 clk = ~clk;

    // Pulse counters: sampled at the posedge, i.e. the value of the cycle
    // that just ended.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sent) sent_cnt <= sent_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Called at a negedge; returns at the first negedge after acceptance.
    task automatic start_send(input logic [7:0] c);
        cmd  = c;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    // Counts samples with the clock held low; returns at the first released sample.
    task automatic measure_inhibit(input int already);
        int n = already;
        while (ps2_clk == 1'b0 && n < INH * 4) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_len", n, INH);
        chk("start_bit", ps2_dat, 0);
    endtask

    // Device: generates nedges clock pulses, samples host data late in each
    // low phase, drives ACK (unless nack) before the 11th edge.
    task automatic dev_clock(input int nedges, input int hp, input bit nack,
                             output logic [9:0] bits);
        bits = '1;
        for (int i = 0; i < nedges; i++) begin
            if (i == 10) dev_dat_low = !nack;
            repeat (hp) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == 0) fall1_cyc = cyc;
            repeat (hp) @(negedge clk);
            if (i < 10) bits[i] = ps2_dat;
            dev_clk_low = 1'b0;
        end
        repeat (hp) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_outcome(input int s0, input int e0, output bit gs, output bit ge);
        int n = 0;
        while (sent_cnt == s0 && err_cnt == e0 && n < XFER_TO * 2) begin
            @(negedge clk);
            n++;
        end
        gs = (sent_cnt != s0);
        ge = (err_cnt != e0);
    endtask

    task automatic check_frame(input string tag, input logic [9:0] bits, input logic [7:0] c);
        chk({tag, "_data"},   bits[7:0], c);
        chk({tag, "_parity"}, bits[8], odd_parity(c));
        chk({tag, "_stop"},   bits[9], 1);
    endtask

    task automatic finish_outcome(input string tag, input int s0, input int e0, input bit nack);
        bit gs, ge, exp_e;
`ifdef PS2_TX_ACK_CHECK_EN
        exp_e = nack;
`else
        exp_e = 1'b0;
`endif
        wait_outcome(s0, e0, gs, ge);
        chk({tag, "_sent"}, gs, !exp_e);
        chk({tag, "_err"},  ge, exp_e);
        chk({tag, "_busy_after"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_sent_count"}, sent_cnt - s0, !exp_e);
        chk({tag, "_err_count"},  err_cnt - e0, exp_e);
    endtask

    task automatic full_send(input string tag, input logic [7:0] c, input int hp, input bit nack);
        logic [9:0] bits;
        int s0, e0;
        s0 = sent_cnt;
        e0 = err_cnt;
        @(negedge clk);
        start_send(c);
        measure_inhibit(0);
        dev_clock(11, hp, nack, bits);
        check_frame(tag, bits, c);
        finish_outcome(tag, s0, e0, nack);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] c;
        int n, s0, e0, hp;
        bit nack;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sent", sent, 0);
        chk("rst_err",  err, 0);
        chk("rst_clk",  ps2_clk, 1);
        chk("rst_dat",  ps2_dat, 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Device clocking while idle must not start anything.
        s0 = sent_cnt; e0 = err_cnt;
        dev_clock(3, 15, 1'b0, bits);
        repeat (4) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pulses", (sent_cnt - s0) + (err_cnt - e0), 0);

        full_send("ed", 8'hED, 20, 1'b0);
        full_send("ff", 8'hFF, 16, 1'b0);
        full_send("00", 8'h00, 25, 1'b0);

        // Device never clocks after release.
        s0 = sent_cnt; e0 = err_cnt;
        @(negedge clk);
        start_send(8'h55);
        measure_inhibit(0);
        n = 0;
        while (!err && n < START_TO * 2) begin
            @(negedge clk);
            n++;
        end
        chk("rts_timeout", n, START_TO);
        chk("rts_clk_rel", ps2_clk, 1);
        chk("rts_dat_rel", ps2_dat, 1);
        chk("rts_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("rts_sent_count", sent_cnt - s0, 0);
        chk("rts_err_count", err_cnt - e0, 1);

        // Device stops after 4 bits.
        s0 = sent_cnt; e0 = err_cnt;
        @(negedge clk);
        start_send(8'hA3);
        measure_inhibit(0);
        dev_clock(4, 18, 1'b0, bits);
        n = 0;
        while (!err && n < XFER_TO * 2) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_timeout", cyc - fall1_cyc, XFER_TO + SYNC_LAT);
        chk("xfer_bits", bits[3:0], 4'h3);
        repeat (3) @(negedge clk);
        chk("xfer_sent_count", sent_cnt - s0, 0);
        chk("xfer_err_count", err_cnt - e0, 1);

        // NACK from the device.
        full_send("nack", 8'hF0, 20, 1'b1);

        // Reset in the middle of a frame; data bit 4 is forced to 0 so the
        // host is actively driving data when reset hits.
        c = 8'($urandom_range(0, 255)) & 8'hEF;
        s0 = sent_cnt; e0 = err_cnt;
        @(negedge clk);
        start_send(c);
        measure_inhibit(0);
        dev_clock(5, 15, 1'b0, bits);
        chk("pre_reset_bits", bits[4:0], c[4:0]);
        chk("pre_reset_dat", ps2_dat, 0);
        reset = 1'b1;
        #1;
        chk("rst_mid_dat", ps2_dat, 1);
        chk("rst_mid_clk", ps2_clk, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_outs", {sent, err}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_pulses", (sent_cnt - s0) + (err_cnt - e0), 0);
        full_send("f4", 8'hF4, 20, 1'b0);

        // Second request while busy is ignored.
        c = 8'h12 ^ 8'($urandom_range(1, 255));
        s0 = sent_cnt; e0 = err_cnt;
        @(negedge clk);
        start_send(c);
        cmd  = 8'h12;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        cmd  = 8'h00;
        measure_inhibit(1);
        dev_clock(11, 14, 1'b0, bits);
        check_frame("ignore", bits, c);
        finish_outcome("ignore", s0, e0, 1'b0);

        // Randomized sends, device speed and ACK/NACK.
        for (int k = 0; k < 6; k++) begin
            c    = 8'($urandom_range(0, 255));
            hp   = $urandom_range(12, 25);
            nack = ($urandom_range(0, 3) == 0);
            full_send("rand", c, hp, nack);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_command_sender.md
Name: ps2_command_sender

Overview:
- Host-to-device PS/2 transmitter. Sends one 8-bit command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard on the PS/2 lines already used by the receive path.
- Implements the PS/2 host request-to-send sequence: inhibit the clock, start bit, 8 data bits LSB first, odd parity, stop bit, device ACK.
- Sits beside the keyboard receiver in the top level. Shares PS2_CLK and PS2_DAT. Each line is driven only as open-drain: drive 0 or release to 'z'.

Parameters:
- INHIBIT_CYCLES, 5000: CLOCK_50 cycles PS2_CLK is held low before the start bit (100 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum cycles to wait for the first device falling edge after clock release (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: maximum cycles from the first device falling edge to the end of ACK (2 ms).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high reset
- the_command  input  8  command byte, sampled when a send is accepted
- send_command  input  1  single-cycle request strobe
- PS2_CLK  inout  1  PS/2 clock, open-drain (drive 0 or 'z')
- PS2_DAT  inout  1  PS/2 data, open-drain (drive 0 or 'z')
- busy  output  1  high from acceptance until DONE/ERROR exit
- command_was_sent  output  1  one-cycle pulse on successful completion
- error_communication_timed_out  output  1  one-cycle pulse on any timeout (or NACK, see Optional Feature)

Behaviour:
- Clock and reset: one clock domain, CLOCK_50. Reset is asynchronous and active-high.
- Reset values: state=IDLE; both lines released; busy=0; command_was_sent=0; error_communication_timed_out=0; counters=0.
- Reset mid-transfer: both lines released on the same edge as reset assertion. Any partial frame is abandoned with no pulses.
- Input sync: PS2_CLK and PS2_DAT pass through a 2-flop synchronizer. falling = sync_clk_prev & ~sync_clk.
- Frame latch: on acceptance, latch shift[9:0] = {1'b1 stop, ~^the_command odd parity, the_command[7:0]}. bitcnt=0.
- IDLE: lines released. send_command=1 is accepted, busy rises next cycle, go to INHIBIT. send_command while busy is ignored.
- INHIBIT: drive PS2_CLK=0 for INHIBIT_CYCLES. In the final cycle also drive PS2_DAT=0 (start bit), then go to RTS.
- RTS: release PS2_CLK, keep PS2_DAT=0, count the start timeout.
  - On falling edge: go to XFER and start the transfer timeout.
  - If the timeout reaches START_TIMEOUT_CYCLES: go to ERROR.
- XFER: on each falling edge, drive PS2_DAT = shift[bitcnt] (0 → drive 0, 1 → release) and increment bitcnt.
  - Bit order across falling edges 1..10: data bits 0..7, then parity, then stop (released).
  - The data value stays stable until the next falling edge.
  - After bitcnt reaches 10, go to ACK.
- ACK: lines released. On the 11th falling edge, sample sync_dat (0 = ACK), then go to WAIT_IDLE.
- WAIT_IDLE: wait until sync_clk=1 and sync_dat=1 (device released the bus), then go to DONE.
- Transfer timeout: covers XFER, ACK and WAIT_IDLE. If it reaches XFER_TIMEOUT_CYCLES, go to ERROR.
- DONE: command_was_sent=1 for one cycle, busy=0, go to IDLE.
- ERROR: release both lines, error_communication_timed_out=1 for one cycle, busy=0, go to IDLE.
- Back-to-back sends: a new send_command is accepted in IDLE on the cycle after the DONE/ERROR pulse.
- Device drives PS2_CLK low during IDLE: no effect. The receiver owns that traffic.
- Latency: a send is at least INHIBIT_CYCLES+2 cycles plus 11 device clocks.

Optional Feature:
- Macro: PS2_TX_ACK_CHECK_EN.
- Defined: an ACK sample of 1 on the 11th falling edge (NACK) goes to ERROR; command_was_sent does not pulse.
- Undefined: the ACK sample value is ignored and the FSM proceeds to WAIT_IDLE regardless. Timeouts still apply.

Test Plan:
- Send 0xED; bench device clocks at 12.5 kHz and ACKs → PS2_CLK low exactly 5000 cycles; data bits 1,0,1,1,0,1,1,1 (LSB first); parity 1; stop 1; command_was_sent pulses once; busy 0 afterward.
- Send 0xFF → parity bit 1 observed; bench device decodes 0xFF with correct odd parity.
- Send 0x00 → parity bit 1 observed; bench device decodes 0x00 with correct odd parity.
- Device never clocks after RTS → error pulse exactly START_TIMEOUT_CYCLES after clock release; both lines released; busy 0.
- Device stops clocking after 4 bits → error pulse at XFER_TIMEOUT_CYCLES after the first falling edge; no command_was_sent.
- Device NACKs (data=1 at 11th edge) → with PS2_TX_ACK_CHECK_EN: error pulse, no success pulse. Without it: command_was_sent pulses.
- Assert reset at bit 5 of a transfer → lines go 'z' immediately; outputs 0. A following send of 0xF4 completes normally.
- Pulse send_command while busy with 0x12 → ignored; the original byte is transmitted, and only one completion pulse occurs.
